// File: rtl/execute_bitcount_if.sv
// Operand-issue and result handshake channels for the pipelined bit-count unit.
// Producers connect to master; the unit itself connects to slave.
interface execute_bitcount_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [TAGW-1:0]  in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic             out_err;
  logic [TAGW-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_err, out_tag
  );
endinterface

// File: rtl/execute_bitcount.sv
// Two-stage CLZ/CTZ/POPCNT unit: S1 registers per-byte leading-zero and popcount
// summaries, S2 combines them with a group priority pick and an adder tree.
module execute_bitcount #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  execute_bitcount_if.slave bc
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int NG = WIDTH / 8;

  localparam logic [1:0] MODE_CLZ = 2'b00;
  localparam logic [1:0] MODE_CTZ = 2'b01;
  localparam logic [1:0] MODE_POP = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  function automatic logic [3:0] lz8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) n = 4'(7 - i);
    end
    return n;
  endfunction

  function automatic logic [3:0] pc8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

  // Flow-control state
  logic            s1_valid;
  logic            out_valid_q;
  logic            s2_adv;
  logic            s1_adv;
  logic            in_xfer;

  // S1 registers
  logic [3:0]      s1_lz [NG];
  logic [3:0]      s1_pc [NG];
  logic [1:0]      s1_mode;
  logic [TAGW-1:0] s1_tag;
  logic            s1_zero;

  // S2 (output) registers
  logic [CW-1:0]   out_count_q;
  logic            out_zero_q;
  logic            out_err_q;
  logic [TAGW-1:0] out_tag_q;

  assign s2_adv  = !out_valid_q || bc.out_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign in_xfer = bc.in_valid && s1_adv;

  assign bc.in_ready  = s1_adv;
  assign bc.out_valid = out_valid_q;
  assign bc.out_count = out_count_q;
  assign bc.out_zero  = out_zero_q;
  assign bc.out_err   = out_err_q;
  assign bc.out_tag   = out_tag_q;

  // CTZ becomes CLZ of the bit-reversed operand so both share one path.
  logic [WIDTH-1:0] op_rev;
  logic [WIDTH-1:0] op;
  logic [3:0]       g_lz [NG];
  logic [3:0]       g_pc [NG];

  always_comb begin
    op_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      op_rev[i] = bc.in_data[WIDTH-1-i];
    end
    op = (bc.in_mode == MODE_CTZ) ? op_rev : bc.in_data;
  end

  always_comb begin
    for (int g = 0; g < NG; g++) begin
      g_lz[g] = lz8(op[WIDTH-1-8*g -: 8]);
      g_pc[g] = pc8(op[WIDTH-1-8*g -: 8]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_tag   <= '0;
      s1_zero  <= 1'b0;
      for (int g = 0; g < NG; g++) begin
        s1_lz[g] <= '0;
        s1_pc[g] <= '0;
      end
    end else if (s1_adv) begin
      s1_valid <= bc.in_valid;
      if (in_xfer) begin
        s1_mode <= bc.in_mode;
        s1_tag  <= bc.in_tag;
        s1_zero <= ~|bc.in_data;
        for (int g = 0; g < NG; g++) begin
          s1_lz[g] <= g_lz[g];
          s1_pc[g] <= g_pc[g];
        end
      end
    end
  end

  // Group 0 is the most significant byte, so the lowest non-empty index wins.
  logic [CW-1:0] lz_cnt;
  logic [CW-1:0] pc_sum;
  logic [CW-1:0] count_nxt;

  always_comb begin
    lz_cnt = CW'(WIDTH);
    for (int g = NG - 1; g >= 0; g--) begin
      if (s1_lz[g] != 4'd8) lz_cnt = CW'(8 * g) + CW'(s1_lz[g]);
    end
    pc_sum = '0;
    for (int g = 0; g < NG; g++) begin
      pc_sum = pc_sum + CW'(s1_pc[g]);
    end
    case (s1_mode)
      MODE_CLZ, MODE_CTZ: count_nxt = lz_cnt;
      MODE_POP:           count_nxt = pc_sum;
      default:            count_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_count_q <= count_nxt;
        out_zero_q  <= s1_zero;
        out_err_q   <= (s1_mode == MODE_RSV);
        out_tag_q   <= s1_tag;
      end
    end
  end
endmodule
